// File: rtl/cbus_pkg.sv
// Shared CBUS definitions: arbiter state encoding and fabric-wide defaults.
package cbus_pkg;

    typedef enum logic [1:0] {
        CBUS_ARB_IDLE = 2'd0,
        CBUS_ARB_BUSY = 2'd1,
        CBUS_ARB_ACK  = 2'd2
    } cbus_arb_state_e;

    localparam int CBUS_ADDR_W_DEF  = 20;
    localparam int CBUS_DATA_W_DEF  = 32;
    localparam int CBUS_TIMEOUT_DEF = 255;
    localparam int CBUS_ERR_RDATA   = 0;

endpackage

// File: rtl/cbus_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping modulo N.
module cbus_rr_pick
    import cbus_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] cand;

    // Offset N lands back on i_ptr itself, so the last granted master is tried last.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = wrap_add(i_ptr, i);
            if (!o_valid && i_req[cand]) begin
                o_valid     = 1'b1;
                o_idx       = cand;
                o_gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_mst_arb.sv
// Multi-master CBUS arbiter: round-robin grant, registered command, ack/rdata return, timeout.
module cbus_mst_arb
    import cbus_pkg::*;
#(
    parameter int ADDR_W  = CBUS_ADDR_W_DEF,
    parameter int DATA_W  = CBUS_DATA_W_DEF,
    parameter int N_MST   = 4,
    parameter int TIMEOUT = CBUS_TIMEOUT_DEF
) (
    input  logic                      i_clk_sys,
    input  logic                      i_rst_sys,
    input  logic [N_MST-1:0]          i_mst_req,
    input  logic [N_MST-1:0]          i_mst_rw,
    input  logic [N_MST*ADDR_W-1:0]   i_mst_addr,
    input  logic [N_MST*DATA_W-1:0]   i_mst_wdata,
    output logic [N_MST-1:0]          o_mst_ack,
    output logic [N_MST-1:0]          o_mst_err,
    output logic [DATA_W-1:0]         o_mst_rdata,
    output logic                      o_cbus_req,
    output logic                      o_cbus_rw,
    output logic [ADDR_W-1:0]         o_cbus_addr,
    output logic [DATA_W-1:0]         o_cbus_wdata,
    input  logic                      i_cbus_ack,
    input  logic [DATA_W-1:0]         i_cbus_rdata,
    output logic [$clog2(N_MST)-1:0]  o_grant_idx,
    output logic                      o_busy
);

    localparam int IDX_W = $clog2(N_MST);
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    cbus_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic [N_MST-1:0]  ack_q, ack_d;
    logic [N_MST-1:0]  err_q, err_d;

    logic [N_MST-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              pick_rw;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    cbus_rr_pick #(.N(N_MST), .IDX_W(IDX_W)) u_pick (
        .i_req   (i_mst_req),
        .i_ptr   (ptr_q),
        .o_gnt   (pick_gnt),
        .o_idx   (pick_idx),
        .o_valid (pick_valid)
    );

    // One-hot select of the winner's command fields.
    always_comb begin
        pick_rw    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int k = 0; k < N_MST; k++) begin
            if (pick_gnt[k]) begin
                pick_rw    = i_mst_rw[k];
                pick_addr  = i_mst_addr[k*ADDR_W +: ADDR_W];
                pick_wdata = i_mst_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            CBUS_ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = CBUS_ARB_BUSY;
                    ptr_d   = pick_idx;
                    grant_d = pick_idx;
                    rw_d    = pick_rw;
                    addr_d  = pick_addr;
                    wdata_d = pick_wdata;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            CBUS_ARB_BUSY: begin
                // A slave ack on the terminal-count cycle takes priority over the timeout.
                if (i_cbus_ack) begin
                    state_d        = CBUS_ARB_ACK;
                    rdata_d        = i_cbus_rdata;
                    ack_d[grant_q] = 1'b1;
                    req_d          = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_TERM)) begin
                    state_d        = CBUS_ARB_ACK;
                    rdata_d        = DATA_W'(CBUS_ERR_RDATA);
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    req_d          = 1'b0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CBUS_ARB_ACK: begin
                state_d = CBUS_ARB_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = CBUS_ARB_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst_sys) begin
            state_q <= CBUS_ARB_IDLE;
            ptr_q   <= IDX_W'(N_MST - 1);
            grant_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign o_mst_ack    = ack_q;
    assign o_mst_err    = err_q;
    assign o_mst_rdata  = rdata_q;
    assign o_cbus_req   = req_q;
    assign o_cbus_rw    = rw_q;
    assign o_cbus_addr  = addr_q;
    assign o_cbus_wdata = wdata_q;
    assign o_grant_idx  = grant_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_cbus_mst_arb.sv
// Directed bench for cbus_mst_arb: transaction vector table plus hand-written corner sequences.
module tb_cbus_mst_arb;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int N_MST   = 4;
    localparam int TIMEOUT = 8;

    logic                     clk;
    logic                     rst;
    logic [N_MST-1:0]         i_mst_req;
    logic [N_MST-1:0]         i_mst_rw;
    logic [N_MST*ADDR_W-1:0]  i_mst_addr;
    logic [N_MST*DATA_W-1:0]  i_mst_wdata;
    logic [N_MST-1:0]         o_mst_ack;
    logic [N_MST-1:0]         o_mst_err;
    logic [DATA_W-1:0]        o_mst_rdata;
    logic                     o_cbus_req;
    logic                     o_cbus_rw;
    logic [ADDR_W-1:0]        o_cbus_addr;
    logic [DATA_W-1:0]        o_cbus_wdata;
    logic                     i_cbus_ack;
    logic [DATA_W-1:0]        i_cbus_rdata;
    logic [1:0]               o_grant_idx;
    logic                     o_busy;

    cbus_mst_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_MST(N_MST), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk_sys    (clk),
        .i_rst_sys    (rst),
        .i_mst_req    (i_mst_req),
        .i_mst_rw     (i_mst_rw),
        .i_mst_addr   (i_mst_addr),
        .i_mst_wdata  (i_mst_wdata),
        .o_mst_ack    (o_mst_ack),
        .o_mst_err    (o_mst_err),
        .o_mst_rdata  (o_mst_rdata),
        .o_cbus_req   (o_cbus_req),
        .o_cbus_rw    (o_cbus_rw),
        .o_cbus_addr  (o_cbus_addr),
        .o_cbus_wdata (o_cbus_wdata),
        .i_cbus_ack   (i_cbus_ack),
        .i_cbus_rdata (i_cbus_rdata),
        .o_grant_idx  (o_grant_idx),
        .o_busy       (o_busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req;
        logic        rw;
        int          dly;       // BUSY cycle index carrying the slave ack, -1 = never
        logic [31:0] sdata;
        int          exp_idx;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_err;
        logic [31:0] exp_rdata;
        int          exp_busy;
        int          exp_gap;   // cycles since previous o_cbus_req rise, 0 = not checked
    } vec_t;

    vec_t vecs[12];
    logic [ADDR_W-1:0] m_addr[N_MST];
    logic [DATA_W-1:0] m_wdata[N_MST];

    int n_cmp = 0;
    int n_err = 0;
    int last_rise = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   64'(o_mst_ack),    64'h0);
        check({tag, "_err"},   64'(o_mst_err),    64'h0);
        check({tag, "_creq"},  64'(o_cbus_req),   64'h0);
        check({tag, "_busy"},  64'(o_busy),       64'h0);
        check({tag, "_rw"},    64'(o_cbus_rw),    64'h0);
        check({tag, "_addr"},  64'(o_cbus_addr),  64'h0);
        check({tag, "_wdata"}, 64'(o_cbus_wdata), 64'h0);
        check({tag, "_rdata"}, 64'(o_mst_rdata),  64'h0);
        check({tag, "_gidx"},  64'(o_grant_idx),  64'h0);
    endtask

    // Driver: entered and left at a negedge; leaves during the master's ack cycle.
    task automatic run_txn(input int n, input vec_t v);
        bit   seen;
        bit   bus_ok;
        int   busy_n;
        string t;
        t = $sformatf("v%0d", n);
        i_mst_req = v.req;
        i_mst_rw  = {N_MST{v.rw}};
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (o_cbus_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check({t, "_req_timeout"}, 64'h0, 64'h1);
            return;
        end
        if (v.exp_gap != 0) check({t, "_gap"}, 64'(cyc - last_rise), 64'(v.exp_gap));
        last_rise = cyc;
        check({t, "_gidx"}, 64'(o_grant_idx), 64'(v.exp_idx));
        check({t, "_addr"}, 64'(o_cbus_addr), 64'(m_addr[v.exp_idx]));
        check({t, "_rw"},   64'(o_cbus_rw),   64'(v.rw));
        busy_n = 0;
        bus_ok = 1'b1;
        for (int g = 0; g < 40; g++) begin
            if (!o_cbus_req) break;
            busy_n++;
            if (o_cbus_addr !== m_addr[v.exp_idx] || o_cbus_wdata !== m_wdata[v.exp_idx] ||
                o_cbus_rw !== v.rw || o_mst_ack !== 4'b0 || o_busy !== 1'b1)
                bus_ok = 1'b0;
            i_cbus_ack   = (g == v.dly);
            i_cbus_rdata = (g == v.dly) ? v.sdata : 32'h0;
            @(negedge clk);
            i_cbus_ack   = 1'b0;
            i_cbus_rdata = 32'h0;
        end
        check({t, "_bus_stable"}, 64'(bus_ok),      64'h1);
        check({t, "_busy_cyc"},   64'(busy_n),      64'(v.exp_busy));
        check({t, "_ack"},        64'(o_mst_ack),   64'(v.exp_ack));
        check({t, "_err"},        64'(o_mst_err),   64'(v.exp_err));
        check({t, "_rdata"},      64'(o_mst_rdata), 64'(v.exp_rdata));
        check({t, "_busy_ack"},   64'(o_busy),      64'h1);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) run_txn(i, vecs[i]);
    endtask

    initial begin
        m_addr[0] = 20'h00100; m_wdata[0] = 32'h1111_0000;
        m_addr[1] = 20'h01234; m_wdata[1] = 32'h2222_1111;
        m_addr[2] = 20'h00010; m_wdata[2] = 32'h3333_2222;
        m_addr[3] = 20'hFFFFF; m_wdata[3] = 32'hA5A5_A5A5;

        //          req      rw   dly sdata          idx ack      err      rdata          busy gap
        vecs[0]  = '{4'b1111, 1'b1, 0, 32'h1000_0000, 0, 4'b0001, 4'b0000, 32'h1000_0000, 1, 0};
        vecs[1]  = '{4'b1111, 1'b1, 0, 32'h1000_0001, 1, 4'b0010, 4'b0000, 32'h1000_0001, 1, 3};
        vecs[2]  = '{4'b1111, 1'b1, 0, 32'h1000_0002, 2, 4'b0100, 4'b0000, 32'h1000_0002, 1, 3};
        vecs[3]  = '{4'b1111, 1'b1, 0, 32'h1000_0003, 3, 4'b1000, 4'b0000, 32'h1000_0003, 1, 3};
        vecs[4]  = '{4'b1111, 1'b1, 0, 32'h1000_0004, 0, 4'b0001, 4'b0000, 32'h1000_0004, 1, 3};
        vecs[5]  = '{4'b0100, 1'b1, 2, 32'hCAFE_0001, 2, 4'b0100, 4'b0000, 32'hCAFE_0001, 3, 0};
        vecs[6]  = '{4'b1000, 1'b0, 4, 32'h0000_0000, 3, 4'b1000, 4'b0000, 32'h0000_0000, 5, 0};
        vecs[7]  = '{4'b0001, 1'b1, 7, 32'h7777_0000, 0, 4'b0001, 4'b0000, 32'h7777_0000, 8, 0};
        vecs[8]  = '{4'b0010, 1'b0, -1, 32'h0000_0000, 1, 4'b0010, 4'b0010, 32'h0000_0000, 8, 0};
        vecs[9]  = '{4'b1111, 1'b1, 1, 32'h9999_0000, 0, 4'b0001, 4'b0000, 32'h9999_0000, 2, 0};
        vecs[10] = '{4'b1010, 1'b1, 0, 32'h0000_0005, 1, 4'b0010, 4'b0000, 32'h0000_0005, 1, 0};
        vecs[11] = '{4'b1010, 1'b1, 0, 32'h0000_0006, 3, 4'b1000, 4'b0000, 32'h0000_0006, 1, 0};

        rst          = 1'b1;
        i_mst_req    = '0;
        i_mst_rw     = '0;
        i_cbus_ack   = 1'b0;
        i_cbus_rdata = '0;
        for (int k = 0; k < N_MST; k++) begin
            i_mst_addr[k*ADDR_W +: ADDR_W]  = m_addr[k];
            i_mst_wdata[k*DATA_W +: DATA_W] = m_wdata[k];
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Fairness, single read, write pass-through, ack at terminal count, timeout
        run_range(0, 8);

        // Late slave ack five cycles after the timed-out ack must be ignored
        i_mst_req = '0;
        repeat (4) @(negedge clk);
        i_cbus_ack   = 1'b1;
        i_cbus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        i_cbus_ack   = 1'b0;
        i_cbus_rdata = '0;
        check("late_ack_ack",   64'(o_mst_ack),   64'h0);
        check("late_ack_err",   64'(o_mst_err),   64'h0);
        check("late_ack_creq",  64'(o_cbus_req),  64'h0);
        check("late_ack_busy",  64'(o_busy),      64'h0);
        check("late_ack_rdata", 64'(o_mst_rdata), 64'h0);
        @(negedge clk);
        check("late_ack_idle", 64'(o_busy), 64'h0);

        // Reset in the second BUSY cycle of a master-2 read
        i_mst_req = 4'b0100;
        i_mst_rw  = 4'b1111;
        begin
            bit seen_r;
            seen_r = 1'b0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (o_cbus_req) begin
                    seen_r = 1'b1;
                    break;
                end
            end
            check("rst_mid_granted", 64'(seen_r), 64'h1);
        end
        check("rst_mid_gidx", 64'(o_grant_idx), 64'h2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        i_mst_req = '0;
        check_all_zero("rst_mid");

        // Arbitration after reset restarts at master 0, then skips idle masters
        run_range(9, 11);

        i_mst_req = '0;
        @(negedge clk);
        @(negedge clk);
        check("end_idle_busy", 64'(o_busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
